// File: rtl/serial_number_decoder_if.sv
// Byte-stream input and fixed-point number output of the serial number decoder.
// The decoder is the master: it produces num and the status pulses, the environment
// supplies bytes and the consumer's ready.
interface serial_number_decoder_if #(
   parameter int unsigned NUMBER_BITS = 37
);
   logic [7:0]                    receive_byte;
   logic                          receive_valid;
   logic signed [NUMBER_BITS-1:0] num;
   logic                          num_valid;
   logic                          num_ready;
   logic                          pad_error;
   logic                          overrun;
   logic                          timeout;
   logic                          receiving;

   modport master (
      input  receive_byte,
      input  receive_valid,
      input  num_ready,
      output num,
      output num_valid,
      output pad_error,
      output overrun,
      output timeout,
      output receiving
   );

   modport slave (
      output receive_byte,
      output receive_valid,
      output num_ready,
      input  num,
      input  num_valid,
      input  pad_error,
      input  overrun,
      input  timeout,
      input  receiving
   );
endinterface

// File: rtl/serial_number_decoder.sv
// Reassembles little-endian signed fixed-point numbers from a UART byte stream.
// The next number assembles in buffer_q while the previous one is held in num_q
// for the consumer. A partial number is dropped after an inter-byte timeout.
module serial_number_decoder #(
   parameter int unsigned NUMBER_BITS     = 37,
   parameter int unsigned NUMBER_BYTES    = 5,
   parameter int unsigned BYTE_INDEX_BITS = 3,
   parameter int unsigned TIMEOUT_CYCLES  = 100000,
   parameter int unsigned TIMEOUT_BITS    = 17
) (
   input logic                     clk,
   input logic                     reset,
   serial_number_decoder_if.master bus
);
   localparam int unsigned TotalBits = NUMBER_BYTES * 8;
   // The last byte is never buffered; it is merged directly on completion.
   localparam int unsigned BufBits   = TotalBits - 8;
   localparam logic [BYTE_INDEX_BITS-1:0] LastIndex = BYTE_INDEX_BITS'(NUMBER_BYTES - 1);
   localparam logic [TIMEOUT_BITS-1:0] TimeoutLast = TIMEOUT_BITS'(TIMEOUT_CYCLES - 1);
   localparam bit TimeoutEn = (TIMEOUT_CYCLES != 0);

   logic [BYTE_INDEX_BITS-1:0]    byte_index_q;
   logic [BufBits-1:0]            buffer_q;
   logic [TIMEOUT_BITS-1:0]       timeout_cnt_q;
   logic signed [NUMBER_BITS-1:0] num_q;
   logic                          num_valid_q;
   logic                          pad_error_q;
   logic                          overrun_q;
   logic                          timeout_q;

   logic                 last_byte;
   logic                 complete;
   logic                 consume;
   logic                 load;
   logic [TotalBits-1:0] assembled;
   logic [TotalBits-1:0] pad_bits;

   // Completion, load/consume decision and the merged number with its pad bits
   always_comb begin
      last_byte = (byte_index_q == LastIndex);
      complete  = bus.receive_valid && last_byte;
      consume   = num_valid_q && bus.num_ready;
      // A number in the same cycle as a consume replaces the held one directly.
      load      = complete && (!num_valid_q || bus.num_ready);
      assembled = {bus.receive_byte, buffer_q};
      pad_bits  = assembled >> NUMBER_BITS;
   end

   // Byte collection, timeout tracking and the registered output stage
   always_ff @(posedge clk) begin
      if (reset) begin
         byte_index_q  <= '0;
         buffer_q      <= '0;
         timeout_cnt_q <= '0;
         num_q         <= '0;
         num_valid_q   <= 1'b0;
         pad_error_q   <= 1'b0;
         overrun_q     <= 1'b0;
         timeout_q     <= 1'b0;
      end else begin
         overrun_q <= 1'b0;
         timeout_q <= 1'b0;

         if (consume) begin
            num_valid_q <= 1'b0;
         end

         if (bus.receive_valid) begin
            // An arriving byte always wins over a coincident timeout.
            timeout_cnt_q <= '0;
            if (last_byte) begin
               byte_index_q <= '0;
               if (load) begin
                  num_q       <= $signed(assembled[NUMBER_BITS-1:0]);
                  num_valid_q <= 1'b1;
                  pad_error_q <= |pad_bits;
               end else begin
                  overrun_q <= 1'b1;
               end
            end else begin
               byte_index_q <= byte_index_q + BYTE_INDEX_BITS'(1);
               for (int i = 0; i < int'(NUMBER_BYTES) - 1; i++) begin
                  if (byte_index_q == BYTE_INDEX_BITS'(i)) begin
                     buffer_q[i*8 +: 8] <= bus.receive_byte;
                  end
               end
            end
         end else if (TimeoutEn && (byte_index_q != '0)) begin
            if (timeout_cnt_q == TimeoutLast) begin
               byte_index_q  <= '0;
               timeout_cnt_q <= '0;
               timeout_q     <= 1'b1;
            end else begin
               timeout_cnt_q <= timeout_cnt_q + TIMEOUT_BITS'(1);
            end
         end else begin
            timeout_cnt_q <= '0;
         end
      end
   end

   assign bus.num       = num_q;
   assign bus.num_valid = num_valid_q;
   assign bus.pad_error = pad_error_q;
   assign bus.overrun   = overrun_q;
   assign bus.timeout   = timeout_q;
   assign bus.receiving = (byte_index_q != '0);
endmodule
